// File: rtl/axis_frame_demux_pkg.sv
// Shared types and defaults for the frame-aware AXIS 1-to-2 demux.
package axis_frame_demux_pkg;

  typedef enum logic {
    ROUTE0 = 1'b0,
    ROUTE1 = 1'b1
  } route_t;

  localparam int DROP_CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/Axis.sv
// Video AXIS link: data plus start-of-frame / end-of-line markers.
// Handshake: a beat transfers on a rising edge where valid && ready; the master holds
// data/sof/eol/valid stable while valid && !ready, and ready may be any function of state.
interface Axis #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  sof;
  logic                  eol;
  logic                  valid;
  logic                  ready;

  modport Master (output data, output sof, output eol, output valid, input ready);
  modport Slave  (input data, input sof, input eol, input valid, output ready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry (main + skid) register slice; s.ready is registered, so downstream ready is cut.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  Axis.Slave  s,
  Axis.Master m
);

  logic [DATA_WIDTH+1:0] main_q;
  logic [DATA_WIDTH+1:0] skid_q;
  logic                  main_v;
  logic                  skid_v;
  logic                  s_fire;
  logic [DATA_WIDTH+1:0] beat_in;

  assign s.ready = !skid_v;
  assign s_fire  = s.valid && !skid_v;
  assign beat_in = {s.sof, s.eol, s.data};

  assign m.valid = main_v;
  assign m.sof   = main_q[DATA_WIDTH+1];
  assign m.eol   = main_q[DATA_WIDTH];
  assign m.data  = main_q[DATA_WIDTH-1:0];

  // The skid entry only fills while main is stalled, so skid_v implies main_v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || m.ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= s_fire;
        if (s_fire) main_q <= beat_in;
      end
    end else if (s_fire) begin
      skid_q <= beat_in;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_frame_demux.sv
// Frame-aware 1-to-2 AXIS router: the route latched on each sof beat holds for the frame.
module axis_frame_demux
  import axis_frame_demux_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  Axis.Slave                        in,
  Axis.Master                       out0,
  Axis.Master                       out1,
  input  logic                      select,
  output logic                      route,
  output logic                      in_frame,
  output logic [DROP_CNT_WIDTH-1:0] dropped
);

  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = 1;

  Axis #(.DATA_WIDTH(DATA_WIDTH)) s0_in ();
  Axis #(.DATA_WIDTH(DATA_WIDTH)) s1_in ();

  route_t                    route_q;
  route_t                    route_next;
  logic                      in_frame_q;
  logic [DROP_CNT_WIDTH-1:0] dropped_q;
  logic                      drop;
  logic                      accept;

  assign route_next = in.sof ? route_t'(select) : route_q;
  // Beats before the first sof have no frame to belong to; they are swallowed and counted.
  assign drop       = !in_frame_q && !in.sof;
  assign in.ready   = !rst && (drop || ((route_next == ROUTE1) ? s1_in.ready : s0_in.ready));
  assign accept     = in.valid && in.ready;

  assign s0_in.data  = in.data;
  assign s0_in.sof   = in.sof;
  assign s0_in.eol   = in.eol;
  assign s0_in.valid = in.valid && !drop && (route_next == ROUTE0);
  assign s1_in.data  = in.data;
  assign s1_in.sof   = in.sof;
  assign s1_in.eol   = in.eol;
  assign s1_in.valid = in.valid && !drop && (route_next == ROUTE1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_q    <= ROUTE0;
      in_frame_q <= 1'b0;
      dropped_q  <= '0;
    end else if (accept) begin
      if (drop) begin
        if (dropped_q != '1) dropped_q <= dropped_q + DROP_ONE;
      end else if (in.sof) begin
        route_q    <= route_next;
        in_frame_q <= 1'b1;
      end
    end
  end

  assign route    = route_q;
  assign in_frame = in_frame_q;
  assign dropped  = dropped_q;

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid0 (
    .clk (clk),
    .rst (rst),
    .s   (s0_in),
    .m   (out0)
  );

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid1 (
    .clk (clk),
    .rst (rst),
    .s   (s1_in),
    .m   (out1)
  );

endmodule

// File: tb/tb_axis_frame_demux.sv
// Directed bench for axis_frame_demux: routing, drop counting, backpressure, reset.
module tb_axis_frame_demux;

  logic        clk;
  logic        rst;
  logic        select;
  logic        route;
  logic        in_frame;
  logic [15:0] dropped;

  Axis #(.DATA_WIDTH(16)) in_if ();
  Axis #(.DATA_WIDTH(16)) o0_if ();
  Axis #(.DATA_WIDTH(16)) o1_if ();

  axis_frame_demux #(.DATA_WIDTH(16), .DROP_CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_if),
    .out0     (o0_if),
    .out1     (o1_if),
    .select   (select),
    .route    (route),
    .in_frame (in_frame),
    .dropped  (dropped)
  );

  int checks = 0;
  int errors = 0;
  int w;
  logic [17:0] exp0_q[$];
  logic [17:0] exp1_q[$];
  logic [17:0] got0_q[$];
  logic [17:0] got1_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Output monitor: a beat visible with valid && ready at negedge transfers on the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o0_if.valid && o0_if.ready) got0_q.push_back({o0_if.sof, o0_if.eol, o0_if.data});
      if (o1_if.valid && o1_if.ready) got1_q.push_back({o1_if.sof, o1_if.eol, o1_if.data});
    end
  end

  // driver tasks
  task automatic send_beat(input logic [15:0] d, input logic s, input logic e, output int waits);
    in_if.data  = d;
    in_if.sof   = s;
    in_if.eol   = e;
    in_if.valid = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (in_if.ready) break;
      waits++;
      if (waits >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout data=%h never accepted", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp0_q.delete();
    exp1_q.delete();
    got0_q.delete();
    got1_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    select = 1'b0;
    in_if.valid = 1'b1;
    in_if.sof = 1'b1;
    in_if.eol = 1'b0;
    in_if.data = 16'h0;
    o0_if.ready = 1'b1;
    o1_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_if.ready); end
    checks++; if (o0_if.valid !== 1'b0) begin errors++; $display("FAIL rst_out0_valid got %b want 0", o0_if.valid); end
    checks++; if (o1_if.valid !== 1'b0) begin errors++; $display("FAIL rst_out1_valid got %b want 0", o1_if.valid); end
    checks++; if (route !== 1'b0) begin errors++; $display("FAIL rst_route got %b want 0", route); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL rst_in_frame got %b want 0", in_frame); end
    checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL rst_dropped got %0d want 0", dropped); end
    in_if.valid = 1'b0;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_route0();
    clear_queues();
    select = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp0_q.push_back({(i == 0), (i == 3 || i == 7), 16'(i)});
      send_beat(16'(i), (i == 0), (i == 3 || i == 7), w);
      checks++; if (w != 0) begin errors++; $display("FAIL r0_accept_waits beat %0d got %0d want 0", i, w); end
      if (i == 0) begin
        checks++;
        if (o0_if.valid !== 1'b1 || o0_if.data !== 16'd0 || o0_if.sof !== 1'b1) begin
          errors++; $display("FAIL r0_latency valid=%b data=%h sof=%b want 1/0000/1", o0_if.valid, o0_if.data, o0_if.sof);
        end
      end
    end
    idle(3);
    checks++; if (got0_q.size() != 8) begin errors++; $display("FAIL r0_count got %0d want 8", got0_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got0_q.size() || got0_q[i] !== exp0_q[i]) begin
        errors++; $display("FAIL r0_beat %0d got %h want %h", i, (i < got0_q.size()) ? got0_q[i] : 18'h0, exp0_q[i]);
      end
    end
    checks++; if (got1_q.size() != 0) begin errors++; $display("FAIL r0_out1_idle got %0d beats want 0", got1_q.size()); end
    checks++; if (route !== 1'b0 || in_frame !== 1'b1) begin errors++; $display("FAIL r0_state route=%b in_frame=%b want 0/1", route, in_frame); end
  endtask

  task automatic test_select_toggle();
    clear_queues();
    for (int i = 0; i < 4; i++) begin
      select = (i % 2 == 0);
      exp1_q.push_back({(i == 0), (i == 3), 16'h30 + 16'(i)});
      send_beat(16'h30 + 16'(i), (i == 0), (i == 3), w);
      if (i == 2) begin
        checks++; if (route !== 1'b1) begin errors++; $display("FAIL tog_route_mid got %b want 1", route); end
      end
    end
    select = 1'b0;
    idle(3);
    checks++; if (route !== 1'b1) begin errors++; $display("FAIL tog_route_end got %b want 1", route); end
    checks++; if (got0_q.size() != 0) begin errors++; $display("FAIL tog_out0_idle got %0d beats want 0", got0_q.size()); end
    checks++; if (got1_q.size() != 4) begin errors++; $display("FAIL tog_count got %0d want 4", got1_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got1_q.size() || got1_q[i] !== exp1_q[i]) begin
        errors++; $display("FAIL tog_beat %0d got %h want %h", i, (i < got1_q.size()) ? got1_q[i] : 18'h0, exp1_q[i]);
      end
    end
  endtask

  task automatic test_drop();
    clear_queues();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    select = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(16'hD0 + 16'(i), 1'b0, 1'b0, w);
      checks++; if (w != 0) begin errors++; $display("FAIL drop_ready beat %0d waited %0d want 0", i, w); end
    end
    idle(1);
    checks++; if (dropped !== 16'd3) begin errors++; $display("FAIL drop_count got %0d want 3", dropped); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL drop_in_frame got %b want 0", in_frame); end
    select = 1'b0;
    exp0_q.push_back({1'b1, 1'b0, 16'h40});
    exp0_q.push_back({1'b0, 1'b1, 16'h41});
    send_beat(16'h40, 1'b1, 1'b0, w);
    send_beat(16'h41, 1'b0, 1'b1, w);
    idle(3);
    checks++; if (got1_q.size() != 0) begin errors++; $display("FAIL drop_out1_idle got %0d beats want 0", got1_q.size()); end
    checks++; if (got0_q.size() != 2) begin errors++; $display("FAIL drop_frame_count got %0d want 2", got0_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got0_q.size() || got0_q[i] !== exp0_q[i]) begin
        errors++; $display("FAIL drop_frame_beat %0d got %h want %h", i, (i < got0_q.size()) ? got0_q[i] : 18'h0, exp0_q[i]);
      end
    end
    checks++; if (dropped !== 16'd3) begin errors++; $display("FAIL drop_count_hold got %0d want 3", dropped); end
  endtask

  task automatic test_backpressure();
    logic [17:0] held;
    logic        fell;
    clear_queues();
    select = 1'b1;
    for (int i = 0; i < 16; i++) exp1_q.push_back({(i == 0), (i == 7 || i == 15), 16'(i)});
    fork
      begin
        for (int i = 0; i < 16; i++) send_beat(16'(i), (i == 0), (i == 7 || i == 15), w);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        o1_if.ready = 1'b0;
        fell = 1'b0;
        @(negedge clk);
        held = {o1_if.sof, o1_if.eol, o1_if.data};
        if (!in_if.ready) fell = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checks++;
          if (o1_if.valid !== 1'b1 || {o1_if.sof, o1_if.eol, o1_if.data} !== held) begin
            errors++; $display("FAIL bp_stall_stable cyc %0d valid=%b got %h want %h", k, o1_if.valid, {o1_if.sof, o1_if.eol, o1_if.data}, held);
          end
          if (k == 0 && !in_if.ready) fell = 1'b1;
        end
        checks++; if (!fell) begin errors++; $display("FAIL bp_ready_fall in.ready stayed 1 want 0 within 2 cycles"); end
        @(posedge clk);
        #1;
        o1_if.ready = 1'b1;
      end
    join
    idle(4);
    checks++; if (got1_q.size() != 16) begin errors++; $display("FAIL bp_count got %0d want 16", got1_q.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got1_q.size() || got1_q[i] !== exp1_q[i]) begin
        errors++; $display("FAIL bp_beat %0d got %h want %h", i, (i < got1_q.size()) ? got1_q[i] : 18'h0, exp1_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    o0_if.ready = 1'b1;
    o1_if.ready = 1'b1;
    select = 1'b0;
    for (int i = 0; i < 4; i++) exp0_q.push_back({(i == 0), (i == 3), 16'h10 + 16'(i)});
    for (int i = 0; i < 4; i++) exp1_q.push_back({(i == 0), (i == 3), 16'h20 + 16'(i)});
    send_beat(16'h10, 1'b1, 1'b0, w);
    send_beat(16'h11, 1'b0, 1'b0, w);
    send_beat(16'h12, 1'b0, 1'b0, w);
    o0_if.ready = 1'b0;
    send_beat(16'h13, 1'b0, 1'b1, w);
    select = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(16'h20 + 16'(i), (i == 0), (i == 3), w);
      checks++; if (w != 0) begin errors++; $display("FAIL b2b_rate beat %0d waited %0d want 0", i, w); end
    end
    idle(2);
    checks++;
    if (o0_if.valid !== 1'b1 || o0_if.data !== 16'h12) begin
      errors++; $display("FAIL b2b_a_held valid=%b data=%h want 1/0012", o0_if.valid, o0_if.data);
    end
    checks++; if (got1_q.size() != 4) begin errors++; $display("FAIL b2b_b_count got %0d want 4", got1_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got1_q.size() || got1_q[i] !== exp1_q[i]) begin
        errors++; $display("FAIL b2b_b_beat %0d got %h want %h", i, (i < got1_q.size()) ? got1_q[i] : 18'h0, exp1_q[i]);
      end
    end
    o0_if.ready = 1'b1;
    idle(4);
    checks++; if (got0_q.size() != 4) begin errors++; $display("FAIL b2b_a_count got %0d want 4", got0_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got0_q.size() || got0_q[i] !== exp0_q[i]) begin
        errors++; $display("FAIL b2b_a_beat %0d got %h want %h", i, (i < got0_q.size()) ? got0_q[i] : 18'h0, exp0_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    o1_if.ready = 1'b0;
    select = 1'b1;
    send_beat(16'h50, 1'b1, 1'b0, w);
    send_beat(16'h51, 1'b0, 1'b0, w);
    checks++; if (o1_if.valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b want 1", o1_if.valid); end
    rst = 1'b1;
    #1;
    checks++; if (o1_if.valid !== 1'b0 || o0_if.valid !== 1'b0) begin errors++; $display("FAIL rm_valid out0=%b out1=%b want 0/0", o0_if.valid, o1_if.valid); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL rm_in_frame got %b want 0", in_frame); end
    checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL rm_dropped got %0d want 0", dropped); end
    checks++; if (route !== 1'b0) begin errors++; $display("FAIL rm_route got %b want 0", route); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    o1_if.ready = 1'b1;
    idle(1);
    send_beat(16'h52, 1'b0, 1'b0, w);
    checks++; if (w != 0) begin errors++; $display("FAIL rm_drop_ready waited %0d want 0", w); end
    idle(3);
    checks++; if (dropped !== 16'd1) begin errors++; $display("FAIL rm_drop_count got %0d want 1", dropped); end
    checks++; if (got0_q.size() != 0 || got1_q.size() != 0) begin errors++; $display("FAIL rm_no_output got %0d/%0d beats want 0/0", got0_q.size(), got1_q.size()); end
  endtask

  initial begin
    test_reset();
    test_route0();
    test_select_toggle();
    test_drop();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
